// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types, constants and helpers for the UART receive path.
//   uart_rx_state_t : receiver FSM states
//   OVERSAMPLE      : oversample ticks per bit
//   MID_SAMPLE      : sample index on which the bit decision is taken
//   baud_div()      : clocks per oversample tick, rounded, minimum 1
//   majority3()     : 2-of-3 vote used for bit sampling
//   even_parity()   : parity bit that makes the ones count of a byte even
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 9;

  // 4-bit views of the sample positions used by the receiver
  localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SMP_MID  = 4'(MID_SAMPLE);

  function automatic int baud_div(input longint clk_freq, input longint baud);
    longint div_l;
    div_l = (clk_freq + baud * 64'sd8) / (baud * 64'sd16);
    if (div_l < 64'sd1) begin
      return 32'sd1;
    end else begin
      return int'(div_l);
    end
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Oversample prescaler: counts 0..DIV-1 and pulses tick on DIV-1.
// While hold is high the count is forced to 0 and no tick is produced, so the
// first tick after hold drops comes exactly DIV clocks later.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   hold  in  synchronous hold/clear of the prescaler
//   tick  out one-clock oversample strobe
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic tick
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = ~hold & (cnt_r == CNT_LAST);

  // prescaler counter, restarts from 0 whenever held or on the last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (hold) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// UART receiver, 16x oversampling with 2-of-3 majority vote on samples 7/8/9.
// Optional even parity bit after D7 when UART_RX_PARITY_EN is defined.
// Ports:
//   clk           in  system clock
//   rst_n         in  asynchronous active-low reset
//   in_signal     in  serial line (idle high, asynchronous)
//   in_RXNE_clear in  clears RXNE/ORE/FE/PE while high
//   out_word      out last accepted byte
//   out_RXNE      out receive buffer not empty
//   out_Rx_ORE    out overrun: frame completed while RXNE was set
//   out_FE        out framing error: stop bit sampled low
//   out_PE        out parity error (only with UART_RX_PARITY_EN)
// ---------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_signal,
  input  logic       in_RXNE_clear,
  output logic [7:0] out_word,
  output logic       out_RXNE,
  output logic       out_Rx_ORE,
  output logic       out_FE
`ifdef UART_RX_PARITY_EN
  ,
  output logic       out_PE
`endif
);

  localparam int         DIV    = baud_div(CLK_FREQ, BAUD);
  localparam logic [3:0] SMP_V7 = SMP_MID - 4'd2;
  localparam logic [3:0] SMP_V8 = SMP_MID - 4'd1;

  uart_rx_state_t state_r, state_nxt_s;

  logic       rx_meta_r;
  logic       rx_s;
  logic       armed_r;
  logic [3:0] smp_r;
  logic [3:0] smp_inc_s;
  logic [2:0] bit_idx_r;
  logic [7:0] shreg_r;
  logic       v7_r;
  logic       v8_r;
  logic       tick_s;
  logic       decide_s;
  logic       bit_end_s;
  logic       vote_s;
  logic       frame_end_s;
  logic       par_ok_s;
`ifdef UART_RX_PARITY_EN
  logic       par_r;
`endif

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (state_r == IDLE),
    .tick  (tick_s)
  );

  // smp counts ticks within a bit; the tick that moves it to N is sample N
  assign smp_inc_s = smp_r + 4'd1;
  assign decide_s  = tick_s & (smp_inc_s == SMP_MID);
  assign bit_end_s = tick_s & (smp_r == SMP_LAST);
  assign vote_s    = majority3(v7_r, v8_r, rx_s);

`ifdef UART_RX_PARITY_EN
  assign par_ok_s = (even_parity(shreg_r) == par_r);
`else
  assign par_ok_s = 1'b1;
`endif

  // two-flop synchronizer, idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= in_signal;
      rx_s      <= rx_meta_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic and frame-end strobe
  always_comb begin
    state_nxt_s = state_r;
    frame_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (armed_r && !rx_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (decide_s && vote_s) begin
          state_nxt_s = IDLE;
        end else if (bit_end_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (bit_end_s && (bit_idx_r == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt_s = PARITY;
`else
          state_nxt_s = STOP;
`endif
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
`endif
      STOP: begin
        // leave on the mid-bit decision so the next start edge is not missed
        if (decide_s) begin
          state_nxt_s = IDLE;
          frame_end_s = 1'b1;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        frame_end_s = 1'b0;
      end
    endcase
  end

  // start arming: IDLE only accepts a start after the line has been seen high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r <= 1'b0;
    end else if (state_r != IDLE) begin
      armed_r <= 1'b0;
    end else if (rx_s) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

  // sample counter, bit index and majority-vote sample capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_r     <= 4'd0;
      bit_idx_r <= 3'd0;
      v7_r      <= 1'b1;
      v8_r      <= 1'b1;
    end else begin
      if (state_r == IDLE) begin
        smp_r <= 4'd0;
      end else if (tick_s) begin
        smp_r <= smp_inc_s;
      end else begin
        smp_r <= smp_r;
      end
      if (state_r != DATA) begin
        bit_idx_r <= 3'd0;
      end else if (bit_end_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end
      if (tick_s && (smp_inc_s == SMP_V7)) begin
        v7_r <= rx_s;
      end else begin
        v7_r <= v7_r;
      end
      if (tick_s && (smp_inc_s == SMP_V8)) begin
        v8_r <= rx_s;
      end else begin
        v8_r <= v8_r;
      end
    end
  end

  // data shift register (LSB first) and received parity bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      if ((state_r == DATA) && decide_s) begin
        shreg_r <= {vote_s, shreg_r[7:1]};
      end else begin
        shreg_r <= shreg_r;
      end
`ifdef UART_RX_PARITY_EN
      if ((state_r == PARITY) && decide_s) begin
        par_r <= vote_s;
      end else begin
        par_r <= par_r;
      end
`endif
    end
  end

  // status register: clear first, then a completing frame overrides the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word   <= 8'h00;
      out_RXNE   <= 1'b0;
      out_Rx_ORE <= 1'b0;
      out_FE     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      out_PE     <= 1'b0;
`endif
    end else begin
      if (in_RXNE_clear) begin
        out_RXNE   <= 1'b0;
        out_Rx_ORE <= 1'b0;
        out_FE     <= 1'b0;
`ifdef UART_RX_PARITY_EN
        out_PE     <= 1'b0;
`endif
      end
      if (frame_end_s) begin
        if (vote_s && par_ok_s) begin
          if (!out_RXNE || in_RXNE_clear) begin
            out_word <= shreg_r;
            out_RXNE <= 1'b1;
          end else begin
            out_Rx_ORE <= 1'b1;
          end
        end else begin
          if (!vote_s) begin
            out_FE <= 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          if (!par_ok_s) begin
            out_PE <= 1'b1;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Directed frames into uart_rx_core (DIV=1, 16 clocks per bit). Expected
// delivery/flag events are queued at stimulus time; a monitor pops and
// compares them whenever RXNE, ORE, FE or PE newly assert.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int RXNE_NOM  = 169;
  localparam int DONE_CLKS = 172;
`else
  localparam int RXNE_NOM  = 153;
  localparam int DONE_CLKS = 156;
`endif

  localparam int EV_BYTE = 0;
  localparam int EV_ORE  = 1;
  localparam int EV_FE   = 2;
  localparam int EV_PE   = 3;

  typedef struct {
    int         kind;
    logic [7:0] word;
  } exp_t;

  exp_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_signal;
  logic       in_RXNE_clear;
  logic [7:0] out_word;
  logic       out_RXNE;
  logic       out_Rx_ORE;
  logic       out_FE;
`ifdef UART_RX_PARITY_EN
  logic       out_PE;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_signal     (in_signal),
    .in_RXNE_clear (in_RXNE_clear),
    .out_word      (out_word),
    .out_RXNE      (out_RXNE),
    .out_Rx_ORE    (out_Rx_ORE),
    .out_FE        (out_FE)
`ifdef UART_RX_PARITY_EN
    ,
    .out_PE        (out_PE)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic check_flags(input string name, input int rxne, input int ore, input int fe);
    check({name, "_rxne"}, out_RXNE, rxne);
    check({name, "_ore"}, out_Rx_ORE, ore);
    check({name, "_fe"}, out_FE, fe);
  endtask

  task automatic push(input int kind, input logic [7:0] w);
    exp_t e;
    e.kind = kind;
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic take_event(input int kind, input logic [7:0] w);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d word 0x%0h, expected none", kind, w);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (e.kind == EV_BYTE) check("event_word", w, e.word);
    end
  endtask

  // all line driving happens 1 time unit after a rising edge
  task automatic hold_bit(input logic v);
    in_signal = v;
    repeat (BIT_CLKS) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_clks(input int n);
    in_signal = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit(^d);
`endif
    hold_bit(stop_v);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic p);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    hold_bit(p);
    hold_bit(1'b1);
  endtask
`endif

  task automatic pulse_clear();
    in_RXNE_clear = 1'b1;
    @(posedge clk);
    #1;
    in_RXNE_clear = 1'b0;
  endtask

  // monitor: a flag counts as a new event when it rises or survives a clear
  initial begin : monitor
    logic rxne_p, ore_p, fe_p, pe_p, clr_e;
    rxne_p = 1'b0;
    ore_p  = 1'b0;
    fe_p   = 1'b0;
    pe_p   = 1'b0;
    forever begin
      @(posedge clk);
      clr_e = in_RXNE_clear;
      @(negedge clk);
      if (out_RXNE && (!rxne_p || clr_e)) take_event(EV_BYTE, out_word);
      if (out_Rx_ORE && (!ore_p || clr_e)) take_event(EV_ORE, out_word);
      if (out_FE && (!fe_p || clr_e)) take_event(EV_FE, out_word);
`ifdef UART_RX_PARITY_EN
      if (out_PE && (!pe_p || clr_e)) take_event(EV_PE, out_word);
      pe_p = out_PE;
`endif
      rxne_p = out_RXNE;
      ore_p  = out_Rx_ORE;
      fe_p   = out_FE;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n         = 1'b0;
    in_signal     = 1'b1;
    in_RXNE_clear = 1'b0;
    #3;
    check("reset_word", out_word, 8'h00);
    check_flags("reset", 0, 0, 0);
`ifdef UART_RX_PARITY_EN
    check("reset_pe", out_PE, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_clks(8);

    // 1: single byte, RXNE latency, clear
    push(EV_BYTE, 8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        automatic int n = 0;
        while (out_RXNE == 1'b0 && n < 400) begin
          @(posedge clk);
          #1;
          n++;
        end
        check_range("rxne_latency", n, RXNE_NOM - 3, RXNE_NOM + 3);
      end
    join
    idle_clks(16);
    check("s1_word", out_word, 8'h55);
    pulse_clear();
    check_flags("s1_clear", 0, 0, 0);

    // 2a: overrun keeps the first byte
    push(EV_BYTE, 8'hA3);
    send_frame(8'hA3, 1'b1);
    idle_clks(8);
    push(EV_ORE, 8'hA3);
    send_frame(8'h3C, 1'b1);
    idle_clks(16);
    check("ovr_word", out_word, 8'hA3);
    check_flags("ovr", 1, 1, 0);
    pulse_clear();
    check_flags("ovr_clear", 0, 0, 0);

    // 2b: clear on the completion cycle lets the new byte win
    push(EV_BYTE, 8'hA3);
    send_frame(8'hA3, 1'b1);
    idle_clks(8);
    push(EV_BYTE, 8'h3C);
    fork
      send_frame(8'h3C, 1'b1);
      begin
        repeat (DONE_CLKS - 1) @(posedge clk);
        #1;
        in_RXNE_clear = 1'b1;
        @(posedge clk);
        #1;
        in_RXNE_clear = 1'b0;
      end
    join
    idle_clks(16);
    check("clr_win_word", out_word, 8'h3C);
    check_flags("clr_win", 1, 0, 0);
    pulse_clear();

    // 3: short glitch is rejected as a false start
    in_signal = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    idle_clks(48);
    check("glitch_word", out_word, 8'h3C);
    check_flags("glitch", 0, 0, 0);

    // 4: bad stop bit followed by a long break, then recovery
    push(EV_FE, 8'h3C);
    send_frame(8'h81, 1'b0);
    repeat (20) hold_bit(1'b0);
    check("fe_word", out_word, 8'h3C);
    check_flags("fe", 0, 0, 1);
    pulse_clear();
    repeat (20) hold_bit(1'b0);
    check_flags("break_single_fe", 0, 0, 0);
    idle_clks(32);
    push(EV_BYTE, 8'h42);
    send_frame(8'h42, 1'b1);
    idle_clks(16);
    check("after_break_word", out_word, 8'h42);

    // 5: async reset in the middle of D4 aborts the frame
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (BIT_CLKS * 5 + 6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_word", out_word, 8'h00);
        check_flags("midrst", 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
      end
    join
    idle_clks(16);
    check("post_rst_word", out_word, 8'h00);
    push(EV_BYTE, 8'h0F);
    send_frame(8'h0F, 1'b1);
    idle_clks(16);
    check("post_rst_rx_word", out_word, 8'h0F);
    check_flags("post_rst_rx", 1, 0, 0);
    pulse_clear();

`ifdef UART_RX_PARITY_EN
    // 6: even parity good and bad
    push(EV_BYTE, 8'h07);
    send_frame_par(8'h07, 1'b1);
    idle_clks(16);
    check("par_good_word", out_word, 8'h07);
    pulse_clear();
    push(EV_PE, 8'h07);
    send_frame_par(8'h07, 1'b0);
    idle_clks(16);
    check("par_bad_pe", out_PE, 1);
    check_flags("par_bad", 0, 0, 0);
    pulse_clear();
    check("par_clear_pe", out_PE, 0);
`endif

    idle_clks(16);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Standalone UART receiver that turns the serial `in_signal` line into bytes, using 16x oversampling and majority-vote bit sampling. It sits on the RX side of the UART datapath, underneath the byte-level controllers. It exposes the status-register style interface those controllers already consume: a data word, an RXNE flag with a clear input, and overrun and framing flags.

## Interface
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz.
- `BAUD`, 115200: line rate in baud.
- `DIV`, `CLK_FREQ/(BAUD*16)` rounded to nearest, minimum 1: clocks per oversample tick (derived; not overridden).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_signal`  in  1  raw serial line; idles high; asynchronous to `clk`.
- `in_RXNE_clear`  in  1  level; while high, clears `out_RXNE`, `out_Rx_ORE`, `out_FE` (and `out_PE`).
- `out_word`  out  8  last accepted byte.
- `out_RXNE`  out  1  receive buffer not empty.
- `out_Rx_ORE`  out  1  overrun: a complete frame arrived while `out_RXNE` was set.
- `out_FE`  out  1  framing error: the stop bit was sampled low.
- `out_PE`  out  1  parity error (present only with `UART_RX_PARITY_EN`).

## Operation
- **Reset values:** all outputs 0, `out_word`=0x00, state IDLE, both synchronizer flops 1.
- **Synchronizer:** 2-flop synchronizer on `in_signal`. Every decision uses the synchronized value `rx_s`.
- **Tick generator:**
  - Counts 0..DIV-1 and emits `tick` when the count equals DIV-1.
  - Held at 0 in IDLE, so the first tick falls DIV clocks after start detection.
- **Sample counter:** `smp` (0..15) advances on each tick. Majority vote over samples 7, 8, 9; the decision is taken on sample 9.
- **States:**
  - IDLE: armed only after `rx_s` has been seen high. `rx_s`=0 while armed → START, `smp`=0.
  - START: vote=1 → false start, back to IDLE (nothing flagged). Vote=0 → wait for `smp`=15 → DATA, bit index 0.
  - DATA: each bit's vote is shifted in LSB first. After bit 7 completes → PARITY if the macro is enabled, else STOP.
  - PARITY: vote is stored as the received parity bit; at `smp`=15 → STOP.
  - STOP: the decision on sample 9 ends the frame, and the FSM returns to IDLE in the same cycle (half-bit early resync).
- **Frame completion (stop=1, parity good or disabled):**
  - If `out_RXNE`=0, or `in_RXNE_clear`=1 in that cycle: `out_word` ← shift register, `out_RXNE` ← 1.
  - Otherwise: byte discarded, `out_word` unchanged, `out_Rx_ORE` ← 1.
- **Stop=0:**
  - Byte discarded and `out_FE` ← 1.
  - IDLE stays disarmed until `rx_s`=1, so a break condition yields exactly one FE and no repeated frames.
- **Flag clearing:** `in_RXNE_clear` clears all flags. When it coincides with a completing frame, the new frame's flags win (RXNE=1, ORE not set).
- **Asynchronous reset mid-frame:** aborts the frame and returns everything to reset values. The partial byte is never delivered.

## Timing
- Start detection happens 2–3 clocks after the falling edge on `in_signal`.
- `out_RXNE` rises on the clock after the stop-bit decision tick:
  - without parity: 153 ticks (9·16+9) after start detection;
  - with parity: 169 ticks.
- `out_word` and `out_RXNE` update in the same cycle.
- Flags clear on the clock after `in_RXNE_clear` is sampled high. A one-cycle pulse is sufficient.
- Tolerates a ±3.5% baud mismatch.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame carries an even-parity bit after D7, and the `out_PE` port exists.
  - Parity mismatch with a good stop bit → byte discarded, `out_PE` ← 1, RXNE unchanged.
  - Parity mismatch with a bad stop bit → both `out_PE` and `out_FE` set.
- `UART_RX_PARITY_EN` undefined: 8N1 frames only, no PARITY state, no `out_PE` port.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `OVERSAMPLE`=16;
  - `MID_SAMPLE`=9;
  - function `baud_div(clk_freq, baud)`, returning the rounded DIV with a minimum of 1.
- Sub-module `uart_baud_tick`: prescaler with a synchronous hold input, emitting `tick`. It is reused later by the TX side.

## Test plan
All scenarios use `CLK_FREQ`=1_600_000 and `BAUD`=100_000 (DIV=1).
1. Send 0x55 (8N1), then pulse clear → `out_word`=0x55. `out_RXNE` rises 153±3 clocks after the start edge; all flags clear one clock after the clear.
2. Send 0xA3, then 0x3C without clearing → `out_word`=0xA3, `out_Rx_ORE`=1, `out_RXNE`=1. Repeat with clear asserted on 0x3C's completion cycle → `out_word`=0x3C, ORE=0.
3. 4-clock low glitch on an idle line → no state change past START, all outputs unchanged.
4. Send 0x81 with the stop bit forced low, then hold the line low for 40 bit times → exactly one `out_FE`=1, RXNE=0. After the line returns high, 0x42 is received correctly.
5. Assert `rst_n`=0 during D4 of 0xF0 → all outputs 0 immediately. The next frame 0x0F is received correctly.
6. With `UART_RX_PARITY_EN`: send 0x07 with parity 1 (good) → `out_word`=0x07. Send 0x07 with parity 0 → `out_PE`=1, byte discarded.
